// File: rtl/token_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : token_receiver                                               |
// | Description : Receive stage behind the data generator. Accepts WIDTH-bit   |
// |               tokens over a four-phase req/ack channel, buffers them in a  |
// |               DEPTH-entry first-word-fall-through FIFO, and presents them  |
// |               on a valid/ready stream. The producer is held off by         |
// |               withholding ack while the FIFO is full.                      |
// | Options     : RX_STATS_EN - adds tok_count / stall_count statistics ports. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   WIDTH        token data width                                            |
// |   DEPTH        FIFO entries (power of two, >= 2)                           |
// | Ports                                                                      |
// |   clk          single clock, rising edge                                   |
// |   rst_n        synchronous active-low reset                                |
// |   in_req       producer request (four-phase)                               |
// |   in_data      token, stable while in_req is high                          |
// |   in_ack       acknowledge to producer (registered)                        |
// |   out_valid    FIFO head valid                                             |
// |   out_data     FIFO head (fall-through)                                    |
// |   out_ready    consumer accepts head                                       |
// |   fifo_count   current occupancy                                           |
// |   tok_count    tokens accepted, wraps          (RX_STATS_EN only)          |
// |   stall_count  back-pressure cycles, saturates (RX_STATS_EN only)          |
// +----------------------------------------------------------------------------+
module token_receiver #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_req,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     in_ack,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   fifo_count
`ifdef RX_STATS_EN
   ,
   output logic [31:0]              tok_count,
   output logic [31:0]              stall_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   // ---------------------------------------------------------------------
   // Receive handshake FSM
   // ---------------------------------------------------------------------
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } state_t;

   state_t          state;
   state_t          state_next;
   logic            push;
   logic            pop;
   logic            full;

   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [WIDTH-1:0] mem [DEPTH];

   // Full is judged on the occupancy before the edge, so a pop in the same
   // cycle never frees room for a push; that push lands one cycle later.
   assign full = (count == FULL_COUNT);

   always_comb begin
      state_next = state;
      push       = 1'b0;
      case (state)
         ST_IDLE: begin
            // A write happens only on the IDLE->ACK step, which guarantees
            // exactly one FIFO entry per four-phase handshake.
            if (in_req && !full) begin
               push       = 1'b1;
               state_next = ST_ACK;
            end
         end
         ST_ACK: begin
            if (!in_req) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ACK is encoded as the single state bit, so in_ack comes straight from
   // the state flop and is glitch-free toward the producer.
   assign in_ack = (state == ST_ACK);

   // ---------------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------------
   assign out_valid  = (count != '0);
   assign pop        = out_valid && out_ready;
   assign out_data   = mem[rd_ptr];
   assign fifo_count = count;

   // Storage is intentionally not reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Optional statistics
   // ---------------------------------------------------------------------
`ifdef RX_STATS_EN
   logic stall_cycle;

   // A stall is a cycle where the producer is asking but is refused only
   // because the FIFO has no room.
   assign stall_cycle = (state == ST_IDLE) && in_req && full;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tok_count   <= '0;
         stall_count <= '0;
      end else begin
         if (push) begin
            tok_count <= tok_count + 32'd1;
         end
         if (stall_cycle && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
         end
      end
   end
`else
   // Statistics disabled: no counters are built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_token_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_token_receiver                                            |
// | Description : Self-checking bench for token_receiver. A queue-based        |
// |               reference of the receive channel and FIFO predicts every     |
// |               output each cycle; directed scenarios plus random tokens.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_token_receiver;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic              clk;
   logic              rst_n;
   logic              in_req;
   logic [WIDTH-1:0]  in_data;
   logic              in_ack;
   logic              out_valid;
   logic [WIDTH-1:0]  out_data;
   logic              out_ready;
   logic [$clog2(DEPTH):0] fifo_count;
`ifdef RX_STATS_EN
   logic [31:0]       tok_count;
   logic [31:0]       stall_count;
`endif

   token_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_req     (in_req),
      .in_data    (in_data),
      .in_ack     (in_ack),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .fifo_count (fifo_count)
`ifdef RX_STATS_EN
      ,
      .tok_count  (tok_count),
      .stall_count(stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: contents of the FIFO, whether ack is currently given,
   // and statistics counters.
   logic [WIDTH-1:0] q[$];
   logic             m_ack;
   logic [31:0]      m_tok;
   logic [31:0]      m_stall;
   logic             toggle_ready;

   int n_assert;
   int n_fail;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed timeout expected handshake progress", tag);
   endtask

   // Compare all outputs with the reference, then advance one clock and
   // update the reference from the inputs that were presented at that edge.
   task automatic cycle();
      logic             do_push;
      logic             do_pop;
      logic             do_stall;
      logic             is_full;
      logic [WIDTH-1:0] sampled;
      check("in_ack", 32'(in_ack), 32'(m_ack));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("fifo_count", 32'(fifo_count), 32'(q.size()));
      if (q.size() != 0) check("out_data", 32'(out_data), 32'(q[0]));
`ifdef RX_STATS_EN
      check("tok_count", tok_count, m_tok);
      check("stall_count", stall_count, m_stall);
`endif
      is_full  = (q.size() == DEPTH);
      do_push  = !m_ack && in_req && !is_full;
      do_stall = !m_ack && in_req && is_full;
      do_pop   = (q.size() != 0) && out_ready;
      sampled  = in_data;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         q.delete();
         m_ack   = 1'b0;
         m_tok   = 32'd0;
         m_stall = 32'd0;
      end else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            q.push_back(sampled);
            m_ack = 1'b1;
            m_tok = m_tok + 32'd1;
         end else if (m_ack && !in_req) begin
            m_ack = 1'b0;
         end
         if (do_stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      end
      if (toggle_ready) out_ready = ~out_ready;
   endtask

   // Full four-phase transfer of one token.
   task automatic send_token(input logic [WIDTH-1:0] d);
      int n;
      in_req  = 1'b1;
      in_data = d;
      n = 0;
      while (!m_ack && n < 64) begin
         cycle();
         n++;
      end
      if (!m_ack) timeout("send_ack_rise");
      in_req = 1'b0;
      n = 0;
      while (m_ack && n < 64) begin
         cycle();
         n++;
      end
      if (m_ack) timeout("send_ack_fall");
   endtask

   task automatic drain();
      int n;
      in_req       = 1'b0;
      toggle_ready = 1'b0;
      out_ready    = 1'b1;
      n = 0;
      while ((q.size() != 0 || m_ack) && n < 64) begin
         cycle();
         n++;
      end
      if (q.size() != 0 || m_ack) timeout("drain");
      cycle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_assert     = 0;
      n_fail       = 0;
      toggle_ready = 1'b0;
      m_ack        = 1'b0;
      m_tok        = 32'd0;
      m_stall      = 32'd0;
      rst_n        = 1'b0;
      in_req       = 1'b1;
      in_data      = 8'h3C;
      out_ready    = 1'b0;

      // Reset with request held: nothing may be acknowledged.
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) cycle();
      rst_n = 1'b1;
      cycle();
      check("first_ack", 32'(in_ack), 32'd1);
      drain();

      // Single token with consumer ready.
      out_ready = 1'b1;
      send_token(8'hA5);
      drain();

      // Fill to DEPTH with no consumer, then hold a fifth request.
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send_token(WIDTH'(i));
      check("full_count", 32'(fifo_count), 32'd4);
      in_req  = 1'b1;
      in_data = 8'h05;
      for (int i = 0; i < 3; i++) cycle();
      check("held_ack", 32'(in_ack), 32'd0);
`ifdef RX_STATS_EN
      check("held_stalls", stall_count, 32'd3);
`endif
      out_ready = 1'b1;
      cycle();
      check("no_push_on_pop", 32'(in_ack), 32'd0);
      cycle();
      check("push_after_pop", 32'(in_ack), 32'd1);
      drain();

      // Random stream with consumer toggling every cycle.
      do_reset();
      toggle_ready = 1'b1;
      out_ready    = 1'b0;
      for (int i = 0; i < 20; i++) begin
         send_token(WIDTH'($urandom));
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) cycle();
      end
`ifdef RX_STATS_EN
      check("tok_total", tok_count, 32'd20);
`endif
      drain();

      // Simultaneous push and pop with two entries held.
      out_ready = 1'b0;
      send_token(8'h11);
      send_token(8'h22);
      in_req    = 1'b1;
      in_data   = 8'h33;
      out_ready = 1'b1;
      cycle();
      check("simul_count", 32'(fifo_count), 32'd2);
      out_ready = 1'b0;
      in_req    = 1'b0;
      cycle();
      drain();

      // Reset while acknowledging with three entries stored.
      out_ready = 1'b0;
      send_token(8'h44);
      send_token(8'h55);
      in_req  = 1'b1;
      in_data = 8'h66;
      for (int n = 0; n < 64 && !m_ack; n++) cycle();
      check("pre_rst_count", 32'(fifo_count), 32'd3);
      rst_n = 1'b0;
      cycle();
      check("rst_ack", 32'(in_ack), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
`ifdef RX_STATS_EN
      check("rst_tok", tok_count, 32'd0);
      check("rst_stall", stall_count, 32'd0);
`endif
      rst_n  = 1'b1;
      in_req = 1'b0;
      cycle();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
